sm_regdump: RTL and testbench

- Initiator/reader for the sm_cpu debug register port (regAddr out, regData in).
- On a start pulse it sweeps register addresses FIRST_REG..LAST_REG and captures each regData value.
- Each register is emitted as a 5-byte record on a valid/ready byte stream, which feeds a UART transmitter or FPGA debug FIFO.
- Lets hardware dump CPU state without a simulator.

---
 rtl/sm_debug_pkg.sv | 28 ++
 rtl/sm_regdump_ser.sv | 48 ++++
 rtl/sm_regdump.sv | 81 ++++++++
 tb/tb_sm_regdump.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sm_debug_pkg.sv
// Shared definitions for the sm_cpu debug register dump path: FSM state
// encoding, record geometry and the record byte selector.
package sm_debug_pkg;

  localparam int ADDR_W    = 5;
  localparam int REC_BYTES = 5;
  localparam int IDX_W     = 3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_BYTES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Payload byte for record positions 1..4, most significant byte first.
  function automatic logic [7:0] rec_byte(input logic [31:0] value,
                                          input logic [IDX_W-1:0] idx);
    case (idx)
      3'd1:    rec_byte = value[31:24];
      3'd2:    rec_byte = value[23:16];
      3'd3:    rec_byte = value[15:8];
      3'd4:    rec_byte = value[7:0];
      default: rec_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/sm_regdump_ser.sv
// Record serializer: captures one register value on load and presents the
// 5-byte record (address byte, then value MSB first) on a valid/ready stream.
module sm_regdump_ser
  import sm_debug_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       value,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [7:0]        out_data,
  output logic              last_byte_accepted
);

  logic [31:0]      capture;
  logic [IDX_W-1:0] idx;
  logic             handshake;

  assign handshake          = out_valid && out_ready;
  assign last_byte_accepted = handshake && (idx == LAST_IDX);

  // Capture on load, then advance one byte per handshake; hold while stalled.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      capture   <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      capture   <= value;
      idx       <= '0;
      out_valid <= 1'b1;
      out_data  <= {3'b000, addr};
    end else if (handshake) begin
      if (idx == LAST_IDX) begin
        out_valid <= 1'b0;
      end else begin
        idx      <= idx + 3'd1;
        out_data <= rec_byte(capture, idx + 3'd1);
      end
    end
  end

endmodule

// File: rtl/sm_regdump.sv
// Debug register dumper: sweeps FIRST_REG..LAST_REG on the sm_cpu debug
// port and streams one 5-byte record per register.
module sm_regdump
  import sm_debug_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] regAddr,
  input  logic [31:0]       regData,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

  logic [1:0] state;
  logic       load;
  logic       last_byte_accepted;

  assign load = (state == ST_LOAD);

  // Sweep controller. A start landing on the done pulse is dropped so a
  // finishing dump can never chain straight into a new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      regAddr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !done) begin
            regAddr <= FIRST_A;
            busy    <= 1'b1;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: state <= ST_SEND;
        ST_SEND: begin
          if (last_byte_accepted) begin
            if (regAddr == LAST_A) begin
              state <= ST_DONE;
            end else begin
              regAddr <= regAddr + 1'b1;
              state   <= ST_LOAD;
            end
          end
        end
        default: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          regAddr <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  sm_regdump_ser u_ser (
    .clk                (clk),
    .rst_n              (rst_n),
    .load               (load),
    .addr               (regAddr),
    .value              (regData),
    .out_ready          (out_ready),
    .out_valid          (out_valid),
    .out_data           (out_data),
    .last_byte_accepted (last_byte_accepted)
  );

endmodule

// File: tb/tb_sm_regdump.sv
// Directed bench for sm_regdump: full sweep, single-register sweep, random
// backpressure, ignored starts, mid-dump reset and capture-once behaviour.
module tb_sm_regdump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;
  logic        done;
  logic [31:0] rf [32];

  logic        start2;
  logic [4:0]  reg_addr2;
  logic [31:0] reg_data2;
  logic        out_valid2;
  logic        out_ready2;
  logic [7:0]  out_data2;
  logic        busy2;
  logic        done2;
  logic [31:0] rf2 [32];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          start_cyc;
  int          done_cnt;
  int          done_cyc;
  bit          mon_en  = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data;
  logic [7:0]  got [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign reg_data  = rf[reg_addr];
  assign reg_data2 = rf2[reg_addr2];

  sm_regdump #(.FIRST_REG(0), .LAST_REG(31)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .regAddr(reg_addr),
    .regData(reg_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done)
  );

  sm_regdump #(.FIRST_REG(2), .LAST_REG(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .regAddr(reg_addr2),
    .regData(reg_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .busy(busy2), .done(done2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Byte k of the full sweep when rf[i] = i * 16'h0101.
  function automatic logic [7:0] exp_byte(input int k);
    int r = k / 5;
    int b = k % 5;
    return (b == 1 || b == 2) ? 8'h00 : 8'(r);
  endfunction

  // Stream monitor for the full-range instance: collects accepted bytes,
  // records done pulses and checks stalled bytes are held.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) check("hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, prev_data});
      if (out_valid && out_ready) got.push_back(out_data);
      if (done) begin
        done_cnt++;
        done_cyc = cyc - start_cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic fill_rf();
    for (int i = 0; i < 32; i++) rf[i] = 32'(i * 16'h0101);
  endtask

  // Full sweep with ready high (mode 0) or ~30% random ready (mode 1);
  // extra start pulses mid-dump, in the DONE cycle and on the done pulse.
  task automatic run_dump(input int mode, input bit extra);
    bit finished = 1'b0;
    got.delete();
    done_cnt = 0;
    done_cyc = -1;
    @(posedge clk); #1;
    start_cyc = cyc;
    start     = 1'b1;
    out_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
    mon_en    = 1'b1;
    for (int n = 1; n < 4000; n++) begin
      @(posedge clk); #1;
      start     = extra && (n == 50 || n == 193 || n == 194);
      out_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
      if (done_cnt > 0 && (cyc - start_cyc) > done_cyc + 8) begin
        finished = 1'b1;
        break;
      end
    end
    start  = 1'b0;
    mon_en = 1'b0;
    check("dump_finished", 32'(finished), 32'd1);
    check("byte_count", got.size(), 32'd160);
    for (int k = 0; k < got.size() && k < 160; k++)
      check($sformatf("byte%0d", k), 32'(got[k]), 32'(exp_byte(k)));
    check("done_count", done_cnt, 32'd1);
    if (mode == 0) check("done_cycle", done_cyc, 32'd194);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_addr", 32'(reg_addr), 32'd0);
  endtask

  initial begin
    bit seen;
    int d2;
    logic [7:0] b2 [$];
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    start2 = 1'b0; out_ready2 = 1'b1;
    fill_rf();
    for (int i = 0; i < 32; i++) rf2[i] = 32'h0;
    rf2[2] = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(reg_addr), 32'd0);
    rst_n = 1'b1;

    // Single register sweep: FIRST_REG = LAST_REG = 2.
    @(posedge clk); #1;
    start2 = 1'b1;
    d2 = -1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      check($sformatf("busy2_c%0d", n), 32'(busy2), 32'((n >= 1 && n <= 7) ? 1 : 0));
      if (out_valid2 && out_ready2) b2.push_back(out_data2);
      if (done2) d2 = n;
      @(posedge clk); #1;
      start2 = 1'b0;
    end
    check("rec2_len", b2.size(), 32'd5);
    for (int k = 0; k < b2.size() && k < 5; k++) begin
      logic [39:0] rec2 = 40'h02DEADBEEF;
      check($sformatf("rec2_b%0d", k), 32'(b2[k]), 32'(rec2[39 - 8*k -: 8]));
    end
    check("done2_cycle", d2, 32'd8);

    run_dump(0, 1'b0);
    run_dump(1, 1'b0);
    run_dump(0, 1'b1);

    // Capture-once: change rf[0] while record 0 is stalled.
    got.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    start_cyc = cyc;
    start = 1'b1; out_ready = 1'b0; mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check("stall_valid", 32'(seen), 32'd1);
    rf[0] = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;

    // Reset while register 5 is being sent.
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = out_valid && (reg_addr == 5'd5);
    end
    check("reach_reg5", 32'(seen), 32'd1);
    for (int k = 0; k < 5; k++)
      check($sformatf("cap_b%0d", k), (k < got.size()) ? 32'(got[k]) : 32'hFFFF, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_addr", 32'(reg_addr), 32'd0);
    mon_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    fill_rf();
    run_dump(0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
